main_memory: RTL and testbench

//  Block-granular backing store with fixed read/write latency.

---
 rtl/main_memory.sv | 235 +++++++++++++++++++++++
 tb/tb_main_memory.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory.sv
// ---------------------------------------------------------------------------
// main_memory
//   Block-granular backing store with fixed read and write latency. It sits
//   below the cache controller and serves line fills and dirty write-backs.
//   A simultaneous write-back and fill is serialised: the write commits
//   first, then the read runs. This makes a combined request to the same
//   line return the data that was just written.
//
// Optional feature (compile-time macro MEM_STATS_EN):
//   When the macro is defined, two 32-bit wrapping counters are added. They
//   count completed reads and committed writes and clear on reset.
//
// Ports
//   clk           in   clock
//   rst_n         in   synchronous active-low reset
//   mem_rd_en     in   fill request (level)
//   mem_rd_addr   in   fill byte address
//   mem_wr_en     in   write-back request (level)
//   mem_wr_addr   in   write-back byte address
//   mem_wr_blk    in   write-back line
//   mem_busy      out  high while a request is in progress (registered)
//   mem_rd_valid  out  1-cycle pulse, mem_rd_blk carries the fill line
//   mem_rd_blk    out  fill line, held until the next read completes
//   mem_wr_done   out  1-cycle pulse, the write-back line is committed
//   dbg_state_o   out  current FSM state (0 idle, 1 write, 2 read)
//   stat_rd_cnt   out  completed reads   (MEM_STATS_EN only)
//   stat_wr_cnt   out  committed writes  (MEM_STATS_EN only)
//
// Request/response protocol:
//   A request is accepted on any cycle where mem_busy is low and
//   mem_rd_en or mem_wr_en is high. The addresses and the line are captured
//   on that cycle. While mem_busy is high, enables and data are ignored and
//   are not queued. Completion is signalled by the one-cycle pulses. In the
//   pulse cycle mem_busy is already low, so an enable still held in that
//   cycle starts a new request. The requester drops its enables on the pulse.
// ---------------------------------------------------------------------------
module main_memory #(
    parameter int PA_WIDTH  = 32,
    parameter int BLK_WIDTH = 128,
    parameter int MEM_BLKS  = 1024,
    parameter int RD_LAT    = 4,
    parameter int WR_LAT    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_rd_en,
    input  logic [PA_WIDTH-1:0]  mem_rd_addr,
    input  logic                 mem_wr_en,
    input  logic [PA_WIDTH-1:0]  mem_wr_addr,
    input  logic [BLK_WIDTH-1:0] mem_wr_blk,
    output logic                 mem_busy,
    output logic                 mem_rd_valid,
    output logic [BLK_WIDTH-1:0] mem_rd_blk,
    output logic                 mem_wr_done,
    output logic [1:0]           dbg_state_o
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]          stat_rd_cnt,
    output logic [31:0]          stat_wr_cnt
`endif
);

    localparam int OFF     = $clog2(BLK_WIDTH / 8);
    localparam int IDX_W   = $clog2(MEM_BLKS);
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    generate
        if (RD_LAT < 1) begin : g_rd_lat_chk
            $error("main_memory: RD_LAT must be at least 1");
        end
        if (WR_LAT < 1) begin : g_wr_lat_chk
            $error("main_memory: WR_LAT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pend_rd_q, pend_rd_d;
    logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
    logic [BLK_WIDTH-1:0] wr_blk_q, wr_blk_d;
    logic                 busy_q;
    logic                 rd_valid_q, rd_valid_d;
    logic                 wr_done_q, wr_done_d;
    logic [BLK_WIDTH-1:0] rd_blk_q;
    logic                 mem_we;
    logic                 rd_fire;

    logic [BLK_WIDTH-1:0] mem_q [MEM_BLKS];

    // Only the line-index field of each address matters. The offset bits and
    // the bits above the index are don't-care, so upper bits alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_rd_addr, mem_wr_addr};

    // ---------------- next-state / output decode ----------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_rd_d  = pend_rd_q;
        rd_idx_d   = rd_idx_q;
        wr_idx_d   = wr_idx_q;
        wr_blk_d   = wr_blk_q;
        rd_valid_d = 1'b0;
        wr_done_d  = 1'b0;
        mem_we     = 1'b0;
        rd_fire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_rd_en || mem_wr_en) begin
                    rd_idx_d = mem_rd_addr[OFF +: IDX_W];
                    wr_idx_d = mem_wr_addr[OFF +: IDX_W];
                    wr_blk_d = mem_wr_blk;
                    if (mem_wr_en) begin
                        // The write always goes first. A fill that arrives
                        // with it is remembered and runs afterwards.
                        state_d   = S_WRITE;
                        cnt_d     = CNT_W'(WR_LAT - 1);
                        pend_rd_d = mem_rd_en;
                    end else begin
                        state_d   = S_READ;
                        cnt_d     = CNT_W'(RD_LAT - 1);
                        pend_rd_d = 1'b0;
                    end
                end
            end

            S_WRITE: begin
                if (cnt_q == '0) begin
                    mem_we    = 1'b1;
                    wr_done_d = 1'b1;
                    if (pend_rd_q) begin
                        state_d   = S_READ;
                        cnt_d     = CNT_W'(RD_LAT - 1);
                        pend_rd_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_READ: begin
                if (cnt_q == '0) begin
                    rd_fire    = 1'b1;
                    rd_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pend_rd_q  <= 1'b0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            wr_blk_q   <= '0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_blk_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_rd_q  <= pend_rd_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            wr_blk_q   <= wr_blk_d;
            busy_q     <= (state_d != S_IDLE);
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
            if (rd_fire) begin
                rd_blk_q <= mem_q[rd_idx_q];
            end
        end
    end

    // ---------------- storage array (not reset) ----------------
    // A reset that coincides with the commit cycle aborts the write, so an
    // interrupted request never reaches the array.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[wr_idx_q] <= wr_blk_q;
        end
    end

`ifdef MEM_STATS_EN
    logic [31:0] stat_rd_q;
    logic [31:0] stat_wr_q;

    // The counters step on the same edge that raises the matching pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            if (rd_fire) begin
                stat_rd_q <= stat_rd_q + 32'd1;
            end
            if (mem_we) begin
                stat_wr_q <= stat_wr_q + 32'd1;
            end
        end
    end

    assign stat_rd_cnt = stat_rd_q;
    assign stat_wr_cnt = stat_wr_q;
`endif

    assign mem_busy     = busy_q;
    assign mem_rd_valid = rd_valid_q;
    assign mem_rd_blk   = rd_blk_q;
    assign mem_wr_done  = wr_done_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_main_memory.sv
// ---------------------------------------------------------------------------
// tb_main_memory
//   Bench for main_memory with default parameters. The model tracks the
//   accepted request as a set of scheduled cycle numbers: busy window,
//   commit cycle and data cycle. It keeps a plain array image of the stored
//   lines. A compare process checks every output on every cycle after the
//   first reset. The directed scenarios pin latencies and data with literal
//   values, then a randomized phase exercises overlap, aliasing and
//   mid-request resets.
// ---------------------------------------------------------------------------
module tb_main_memory;

    localparam int PA  = 32;
    localparam int BLK = 128;
    localparam int NB  = 1024;
    localparam int RL  = 4;
    localparam int WL  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n = 1'b0;
    logic           mem_rd_en = 1'b0;
    logic [PA-1:0]  mem_rd_addr = '0;
    logic           mem_wr_en = 1'b0;
    logic [PA-1:0]  mem_wr_addr = '0;
    logic [BLK-1:0] mem_wr_blk = '0;
    logic           mem_busy;
    logic           mem_rd_valid;
    logic [BLK-1:0] mem_rd_blk;
    logic           mem_wr_done;
    logic [1:0]     dbg_state;
`ifdef MEM_STATS_EN
    logic [31:0]    stat_rd_cnt;
    logic [31:0]    stat_wr_cnt;
`endif

    main_memory #(
        .PA_WIDTH (PA),
        .BLK_WIDTH(BLK),
        .MEM_BLKS (NB),
        .RD_LAT   (RL),
        .WR_LAT   (WL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_blk  (mem_wr_blk),
        .mem_busy    (mem_busy),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_blk  (mem_rd_blk),
        .mem_wr_done (mem_wr_done),
        .dbg_state_o (dbg_state)
`ifdef MEM_STATS_EN
        ,
        .stat_rd_cnt (stat_rd_cnt),
        .stat_wr_cnt (stat_wr_cnt)
`endif
    );

    // Cycle k is the interval after rising edge k.
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic int idx_of(input logic [PA-1:0] a);
        return int'((a / 32'd16) % NB);
    endfunction

    // ---------------- scoreboard / reference model ----------------
    logic [BLK-1:0] model_mem [NB];
    bit             known [NB];
    logic [BLK-1:0] exp_q[$];      // fill lines still expected from the DUT
    bit             exp_known_q[$];
    int             acc_at   = -1;
    int             busy_end = -1;
    int             done_at  = -1;
    int             valid_at = -1;
    int             clear_at = -1;
    int             m_wr_idx = 0;
    int             m_rd_idx = 0;
    logic [BLK-1:0] m_wr_blk = '0;
    logic [BLK-1:0] exp_blk  = '0;
    bit             exp_blk_known = 1'b0;
    bit             model_on = 1'b0;
    int             exp_rd_cnt = 0;
    int             exp_wr_cnt = 0;

    initial begin
        for (int i = 0; i < NB; i++) known[i] = 1'b0;
    end

    initial begin
        int  c;
        bit  e_busy, e_done, e_valid;
        forever begin
            @(negedge clk);
            c = cyc_cnt;
            if (c == clear_at) begin
                model_on      = 1'b1;
                exp_blk       = '0;
                exp_blk_known = 1'b1;
                exp_rd_cnt    = 0;
                exp_wr_cnt    = 0;
                exp_q.delete();
                exp_known_q.delete();
            end
            e_done = (c == done_at);
            if (e_done) begin
                model_mem[m_wr_idx] = m_wr_blk;
                known[m_wr_idx]     = 1'b1;
                exp_wr_cnt++;
            end
            e_valid = (c == valid_at);
            if (e_valid) begin
                exp_q.push_back(model_mem[m_rd_idx]);
                exp_known_q.push_back(known[m_rd_idx]);
                exp_blk       = exp_q.pop_front();
                exp_blk_known = exp_known_q.pop_front();
                exp_rd_cnt++;
            end
            e_busy = (c > acc_at) && (c <= busy_end);

            if (model_on) begin
                check("busy", BLK'(mem_busy), BLK'(e_busy));
                check("rd_valid", BLK'(mem_rd_valid), BLK'(e_valid));
                check("wr_done", BLK'(mem_wr_done), BLK'(e_done));
                if (exp_blk_known) check("rd_blk", mem_rd_blk, exp_blk);
`ifdef MEM_STATS_EN
                check("stat_rd", BLK'(stat_rd_cnt), BLK'(exp_rd_cnt));
                check("stat_wr", BLK'(stat_wr_cnt), BLK'(exp_wr_cnt));
`endif
            end

            // Inputs presented during cycle c take effect at edge c+1.
            if (!rst_n) begin
                clear_at = c + 1;
                if (done_at > c)  done_at  = -1;
                if (valid_at > c) valid_at = -1;
                if (busy_end > c) busy_end = c;
            end else if (model_on && !e_busy && (mem_rd_en || mem_wr_en)) begin
                acc_at   = c;
                m_wr_idx = idx_of(mem_wr_addr);
                m_rd_idx = idx_of(mem_rd_addr);
                m_wr_blk = mem_wr_blk;
                done_at  = mem_wr_en ? c + WL + 1 : -1;
                valid_at = mem_rd_en ? c + (mem_wr_en ? WL : 0) + RL + 1 : -1;
                busy_end = c + (mem_wr_en ? WL : 0) + (mem_rd_en ? RL : 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    // Presents one request for exactly one cycle; t is that cycle's number.
    task automatic issue(input bit rd, input logic [PA-1:0] ra, input bit wr,
                         input logic [PA-1:0] wa, input logic [BLK-1:0] blk, output int t);
        mem_rd_en   = rd;
        mem_rd_addr = ra;
        mem_wr_en   = wr;
        mem_wr_addr = wa;
        mem_wr_blk  = blk;
        t = cyc_cnt;
        step();
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (mem_wr_done) begin
                at = cyc_cnt;
                return;
            end
            step();
        end
        $display("FAIL wait_done: timed out after %0d cycles", budget);
    endtask

    task automatic wait_valid(input int budget, output int at, output logic [BLK-1:0] blk);
        at  = -1;
        blk = '0;
        for (int i = 0; i < budget; i++) begin
            if (mem_rd_valid) begin
                at  = cyc_cnt;
                blk = mem_rd_blk;
                return;
            end
            step();
        end
        $display("FAIL wait_valid: timed out after %0d cycles", budget);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int             t, at, n;
        logic [BLK-1:0] blk;
        logic [BLK-1:0] pat_a5, pat_11, pat_77, pat_3c, pat_c3;
        pat_a5 = {16{8'hA5}};
        pat_11 = {16{8'h11}};
        pat_77 = {16{8'h77}};
        pat_3c = {16{8'h3C}};
        pat_c3 = {16{8'hC3}};

        step();
        do_reset(3);
        check("rst_busy", BLK'(mem_busy), '0);
        check("rst_valid", BLK'(mem_rd_valid), '0);
        check("rst_done", BLK'(mem_wr_done), '0);
        check("rst_blk", mem_rd_blk, '0);
        check("rst_state", BLK'(dbg_state), '0);

        // 1: single write, done five cycles after acceptance
        issue(1'b0, 32'h0, 1'b1, 32'h40, pat_a5, t);
        wait_done(20, at);
        check("t1_done_lat", BLK'(at - t), BLK'(5));
        check("t1_busy_in_pulse", BLK'(mem_busy), '0);

        // 2: read of the same line through another offset, issued in the pulse cycle
        issue(1'b1, 32'h4C, 1'b0, 32'h0, '0, t);
        wait_valid(20, at, blk);
        check("t2_valid_lat", BLK'(at - t), BLK'(5));
        check("t2_data", blk, pat_a5);

        // 3: combined write + read of one line
        step();
        issue(1'b1, 32'h80, 1'b1, 32'h80, pat_11, t);
        wait_done(20, at);
        check("t3_done_lat", BLK'(at - t), BLK'(5));
        wait_valid(20, at, blk);
        check("t3_valid_lat", BLK'(at - t), BLK'(9));
        check("t3_data", blk, pat_11);

        // 4: read pulse while busy is dropped
        step();
        issue(1'b0, 32'h0, 1'b1, 32'h200, pat_77, t);
        step();
        mem_rd_en   = 1'b1;
        mem_rd_addr = 32'h40;
        step();
        mem_rd_en = 1'b0;
        wait_done(20, at);
        check("t4_done_lat", BLK'(at - t), BLK'(5));
        n = 0;
        repeat (15) begin
            if (mem_rd_valid) n++;
            step();
        end
        check("t4_no_valid", BLK'(n), '0);

        // 5: reset in the middle of a write leaves the old line
        issue(1'b0, 32'h0, 1'b1, 32'h100, pat_3c, t);
        wait_done(20, at);
        step();
        issue(1'b0, 32'h0, 1'b1, 32'h100, pat_c3, t);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t5_rst_blk", mem_rd_blk, '0);
        n = 0;
        repeat (10) begin
            if (mem_wr_done) n++;
            step();
        end
        check("t5_no_done", BLK'(n), '0);
        issue(1'b1, 32'h100, 1'b0, 32'h0, '0, t);
        wait_valid(20, at, blk);
        check("t5_old_line", blk, pat_3c);

`ifdef MEM_STATS_EN
        // 6: counters
        step();
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 32'h40, 1'b0, 32'h0, '0, t);
            wait_valid(20, at, blk);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, 32'h0, 1'b1, 32'h300, pat_77, t);
            wait_done(20, at);
            step();
        end
        check("t6_rd_cnt", BLK'(stat_rd_cnt), BLK'(3));
        check("t6_wr_cnt", BLK'(stat_wr_cnt), BLK'(2));
        do_reset(1);
        check("t6_rd_clr", BLK'(stat_rd_cnt), '0);
        check("t6_wr_clr", BLK'(stat_wr_cnt), '0);
`endif

        // Random phase: held enables, aliasing addresses, rare resets
        for (int i = 0; i < 800; i++) begin
            rst_n       = ($urandom_range(0, 149) != 0);
            mem_rd_en   = ($urandom_range(0, 2) == 0);
            mem_wr_en   = ($urandom_range(0, 2) == 0);
            mem_rd_addr = ($urandom & 32'hFFFF_C000) | (PA'($urandom_range(0, 7)) << 4)
                          | PA'($urandom_range(0, 15));
            mem_wr_addr = ($urandom & 32'hFFFF_C000) | (PA'($urandom_range(0, 7)) << 4)
                          | PA'($urandom_range(0, 15));
            mem_wr_blk  = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        rst_n     = 1'b1;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
